// File: rtl/haraka_pkg.sv
// rtl/haraka_pkg.sv - shared Haraka constant table, sizes and FSM state encoding
package haraka_pkg;

    localparam int HARAKA_NUM_RC = 40;
    localparam int HARAKA_IDX_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } haraka_state_e;

    // Word order follows _mm_set_epi32(a,b,c,d): a is the most significant word
    localparam logic [127:0] HARAKA_RC [HARAKA_NUM_RC] = '{
        128'h0684704c_e620c00a_b2c5fef0_75817b9d,
        128'h8b66b4e1_88f3a06b_640f6ba4_2f08f717,
        128'h3402de2d_53f28498_cf029d60_9f029114,
        128'h0ed6eae6_2e7b4f08_bbf3bcaf_fd5b4f79,
        128'hcbcfb0cb_4872448b_79eecd1c_be397044,
        128'h7eeacdee_6e9032b7_8d5335ed_2b8a057b,
        128'h67c28f43_5e2e7cd0_e2412761_da4fef1b,
        128'h2924d9b0_afcacc07_675ffde2_1fc70b3b,
        128'hab4d63f1_e6867fe9_ecdb8fca_b9d465ee,
        128'h1c30bf84_d4b7cd64_5b2a404f_ad037e33,
        128'hb2cc0bb9_941723bf_69028b2e_8df69800,
        128'hfa0478a6_de6f5572_4aaa9ec8_5c9d2d8a,
        128'hdfb49f2b_6b772a12_0efa4f2e_29129fd4,
        128'h1ea10344_f449a236_32d611ae_bb6a12ee,
        128'haf044988_4b050084_5f9600c9_9ca8eca6,
        128'h21025ed8_9d199c4f_78a2c7e3_27e593ec,
        128'hbf3aaaf8_a759c9b7_b9282ecd_82d40173,
        128'h6260700d_6186b017_37f2efd9_10307d6b,
        128'h5aca45c2_21300443_81c29153_f6fc9ac6,
        128'h9223973c_226b68bb_2caf92e8_36d1943a,
        128'hd3bf9238_225886eb_6cbab958_e51071b4,
        128'hdb863ce5_aef0c677_933dfddd_24e1128d,
        128'hbb606268_ffeba09c_83e48de3_cb2212b1,
        128'h734bd3dc_e2e4d19c_2db91a4e_c72bf77d,
        128'h43bb47c3_61301b43_4b1415c4_2cb3924e,
        128'hdba775a8_e707eff6_03b231dd_16eb6899,
        128'h6df3614b_3c755977_8e5e2302_7eca472c,
        128'hcda75a17_d6de7d77_6d1be5b9_b88617f9,
        128'hec6b43f0_6ba8e9aa_9d6c069d_a946ee5d,
        128'hcb1e6950_f957332b_a2531159_3bf327c1,
        128'h2cee0c75_00da619c_e4ed0353_600ed0d9,
        128'hf0b1a5a1_96e90cab_80bbbabc_63a4a350,
        128'hae3db102_5e962988_ab0dde30_938dca39,
        128'h17bb8f38_d554a40b_8814f3a8_2e75b442,
        128'h34bb8a5b_5f427fd7_aeb6b779_360a16f6,
        128'h26f65241_cbe55438_43ce5918_ffbaafde,
        128'h4ce99a54_b9f3026a_a2ca9cf7_839ec978,
        128'hae51a51a_1bdff7be_40c06e28_22901235,
        128'ha0c1613c_ba7ed22b_c173bc0f_48a659cf,
        128'h756acc03_02288288_4ad6bdfd_e9c59da1
    };

endpackage

// File: rtl/haraka_rc_rom.sv
// rtl/haraka_rc_rom.sv - combinational lookup of one 128-bit Haraka round constant
module haraka_rc_rom
    import haraka_pkg::*;
(
    input  logic [HARAKA_IDX_W-1:0] idx_i,
    output logic [127:0]            rc_o
);

    // Out-of-table indices read as zero rather than wrapping
    always_comb begin
        rc_o = '0;
        if (idx_i < HARAKA_IDX_W'(HARAKA_NUM_RC)) begin
            rc_o = HARAKA_RC[idx_i];
        end
    end

endmodule

// File: rtl/haraka_rc_seq.sv
// rtl/haraka_rc_seq.sv - sequences Haraka round constants as valid/ready steps
module haraka_rc_seq
    import haraka_pkg::*;
#(
    parameter int ROUNDS        = 5,
    parameter int AES_PER_ROUND = 2,
    parameter int LANES         = 4,
    localparam int RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1,
    localparam int AW = (AES_PER_ROUND > 1) ? $clog2(AES_PER_ROUND) : 1
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 start,
    input  logic                 mode512,
    input  logic                 rc_ready,
    output logic                 rc_valid,
    output logic [LANES*128-1:0] rc_data,
    output logic [RW-1:0]        round_idx,
    output logic [AW-1:0]        aes_idx,
    output logic                 busy,
    output logic                 done
);

    haraka_state_e        state_q, state_d;
    logic [RW-1:0]        round_q, round_d;
    logic [AW-1:0]        aes_q, aes_d;
    logic                 mode_q, mode_d;
    logic                 valid_q, valid_d;
    logic [LANES*128-1:0] data_q, data_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic [RW-1:0]           nxt_round, look_round;
    logic [AW-1:0]           nxt_aes, look_aes;
    logic                    last_step;
    logic [HARAKA_IDX_W-1:0] step_idx, base_idx;
    logic [LANES*128-1:0]    lookup_data;

    assign last_step = (round_q == RW'(ROUNDS - 1)) && (aes_q == AW'(AES_PER_ROUND - 1));

    // The table is addressed from registered state only: LOAD fetches the
    // current step, RUN prefetches the successor so an accept never bubbles.
    always_comb begin
        nxt_round = round_q;
        nxt_aes   = aes_q + AW'(1);
        if (aes_q == AW'(AES_PER_ROUND - 1)) begin
            nxt_aes   = '0;
            nxt_round = round_q + RW'(1);
        end
        look_round = (state_q == ST_RUN) ? nxt_round : round_q;
        look_aes   = (state_q == ST_RUN) ? nxt_aes   : aes_q;
        step_idx   = HARAKA_IDX_W'(look_round) * HARAKA_IDX_W'(AES_PER_ROUND)
                   + HARAKA_IDX_W'(look_aes);
        base_idx   = mode_q ? (step_idx << 2) : (step_idx << 1);
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [HARAKA_IDX_W-1:0] lane_idx;
        logic [127:0]            lane_rc;

        assign lane_idx = base_idx + HARAKA_IDX_W'(k);

        haraka_rc_rom u_rom (
            .idx_i (lane_idx),
            .rc_o  (lane_rc)
        );

        assign lookup_data[k*128 +: 128] = (mode_q || (k < 2)) ? lane_rc : 128'd0;
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        aes_d   = aes_q;
        mode_d  = mode_q;
        valid_d = valid_q;
        data_d  = data_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d  = mode512;
                    round_d = '0;
                    aes_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                data_d  = lookup_data;
                valid_d = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (valid_q && rc_ready) begin
                    if (last_step) begin
                        valid_d = 1'b0;
                        data_d  = '0;
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        round_d = nxt_round;
                        aes_d   = nxt_aes;
                        data_d  = lookup_data;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            round_q <= '0;
            aes_q   <= '0;
            mode_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            aes_q   <= aes_d;
            mode_q  <= mode_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rc_valid  = valid_q;
    assign rc_data   = data_q;
    assign round_idx = round_q;
    assign aes_idx   = aes_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_haraka_rc_seq.sv
// tb/tb_haraka_rc_seq.sv - directed self-checking bench for haraka_rc_seq
module tb_haraka_rc_seq;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         start;
    logic         mode512;
    logic         rc_ready;
    logic         rc_valid;
    logic [511:0] rc_data;
    logic [2:0]   round_idx;
    logic [0:0]   aes_idx;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    logic [127:0] tb_rc [0:39] = '{
        128'h0684704c_e620c00a_b2c5fef0_75817b9d, 128'h8b66b4e1_88f3a06b_640f6ba4_2f08f717,
        128'h3402de2d_53f28498_cf029d60_9f029114, 128'h0ed6eae6_2e7b4f08_bbf3bcaf_fd5b4f79,
        128'hcbcfb0cb_4872448b_79eecd1c_be397044, 128'h7eeacdee_6e9032b7_8d5335ed_2b8a057b,
        128'h67c28f43_5e2e7cd0_e2412761_da4fef1b, 128'h2924d9b0_afcacc07_675ffde2_1fc70b3b,
        128'hab4d63f1_e6867fe9_ecdb8fca_b9d465ee, 128'h1c30bf84_d4b7cd64_5b2a404f_ad037e33,
        128'hb2cc0bb9_941723bf_69028b2e_8df69800, 128'hfa0478a6_de6f5572_4aaa9ec8_5c9d2d8a,
        128'hdfb49f2b_6b772a12_0efa4f2e_29129fd4, 128'h1ea10344_f449a236_32d611ae_bb6a12ee,
        128'haf044988_4b050084_5f9600c9_9ca8eca6, 128'h21025ed8_9d199c4f_78a2c7e3_27e593ec,
        128'hbf3aaaf8_a759c9b7_b9282ecd_82d40173, 128'h6260700d_6186b017_37f2efd9_10307d6b,
        128'h5aca45c2_21300443_81c29153_f6fc9ac6, 128'h9223973c_226b68bb_2caf92e8_36d1943a,
        128'hd3bf9238_225886eb_6cbab958_e51071b4, 128'hdb863ce5_aef0c677_933dfddd_24e1128d,
        128'hbb606268_ffeba09c_83e48de3_cb2212b1, 128'h734bd3dc_e2e4d19c_2db91a4e_c72bf77d,
        128'h43bb47c3_61301b43_4b1415c4_2cb3924e, 128'hdba775a8_e707eff6_03b231dd_16eb6899,
        128'h6df3614b_3c755977_8e5e2302_7eca472c, 128'hcda75a17_d6de7d77_6d1be5b9_b88617f9,
        128'hec6b43f0_6ba8e9aa_9d6c069d_a946ee5d, 128'hcb1e6950_f957332b_a2531159_3bf327c1,
        128'h2cee0c75_00da619c_e4ed0353_600ed0d9, 128'hf0b1a5a1_96e90cab_80bbbabc_63a4a350,
        128'hae3db102_5e962988_ab0dde30_938dca39, 128'h17bb8f38_d554a40b_8814f3a8_2e75b442,
        128'h34bb8a5b_5f427fd7_aeb6b779_360a16f6, 128'h26f65241_cbe55438_43ce5918_ffbaafde,
        128'h4ce99a54_b9f3026a_a2ca9cf7_839ec978, 128'hae51a51a_1bdff7be_40c06e28_22901235,
        128'ha0c1613c_ba7ed22b_c173bc0f_48a659cf, 128'h756acc03_02288288_4ad6bdfd_e9c59da1
    };

    haraka_rc_seq dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .start     (start),
        .mode512   (mode512),
        .rc_ready  (rc_ready),
        .rc_valid  (rc_valid),
        .rc_data   (rc_data),
        .round_idx (round_idx),
        .aes_idx   (aes_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    // Step s covers constants 4s..4s+3 (512) or 2s..2s+1 (256)
    function automatic logic [511:0] exp_step(input bit m, input int s);
        logic [511:0] v = '0;
        for (int k = 0; k < 4; k++) begin
            if (m) v[128*k +: 128] = tb_rc[4*s + k];
            else if (k < 2) v[128*k +: 128] = tb_rc[2*s + k];
        end
        return v;
    endfunction

    task automatic kick(input bit m);
        @(negedge CLK);
        mode512 = m;
        start   = 1'b1;
        @(negedge CLK);
        start   = 1'b0;
    endtask

    task automatic test_reset;
        RESET = 1'b1; start = 1'b0; mode512 = 1'b0; rc_ready = 1'b0;
        repeat (2) @(negedge CLK);
        checks++; if (rc_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rc_valid); end
        checks++; if (rc_data !== 512'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", rc_data); end
        checks++; if ({round_idx, aes_idx} !== 4'd0) begin errors++; $display("FAIL reset_idx: got %h expected 0", {round_idx, aes_idx}); end
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done: got %b expected 00", {busy, done}); end
        RESET = 1'b0;
    endtask

    task automatic test_full_512;
        int s = 0, dones = 0, first = -1, last = -1, done_cyc = -1;
        rc_ready = 1'b1;
        kick(1'b1);
        checks++; if ({busy, rc_valid} !== 2'b10) begin errors++; $display("FAIL load_state: got busy,valid=%b expected 10", {busy, rc_valid}); end
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (rc_valid) begin
                if (first < 0) first = c;
                last = c;
                checks++; if (rc_data !== exp_step(1'b1, s)) begin errors++; $display("FAIL full512_data s=%0d: got %h expected %h", s, rc_data, exp_step(1'b1, s)); end
                checks++; if ({round_idx, aes_idx} !== {3'(s / 2), 1'(s % 2)}) begin errors++; $display("FAIL full512_idx s=%0d: got %h expected %h", s, {round_idx, aes_idx}, {3'(s / 2), 1'(s % 2)}); end
                if (s == 0) begin
                    checks++; if (rc_data[127:96] !== 32'h0684704c || rc_data[511:480] !== 32'h0ed6eae6) begin errors++; $display("FAIL first_step_words: got %h %h expected 0684704c 0ed6eae6", rc_data[127:96], rc_data[511:480]); end
                end
                s++;
            end
            if (done) begin dones++; done_cyc = c; end
        end
        checks++; if (s !== 10) begin errors++; $display("FAIL full512_steps: got %0d expected 10", s); end
        checks++; if (last - first + 1 !== 10) begin errors++; $display("FAIL full512_contiguous: got span %0d expected 10", last - first + 1); end
        checks++; if (dones !== 1) begin errors++; $display("FAIL full512_done_count: got %0d expected 1", dones); end
        checks++; if (done_cyc !== last + 1) begin errors++; $display("FAIL full512_done_cycle: got %0d expected %0d", done_cyc, last + 1); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full512_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_mode256;
        int s = 0, dones = 0;
        rc_ready = 1'b1;
        kick(1'b0);
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (rc_valid) begin
                checks++; if (rc_data !== exp_step(1'b0, s)) begin errors++; $display("FAIL m256_data s=%0d: got %h expected %h", s, rc_data, exp_step(1'b0, s)); end
                if (s == 2) begin
                    checks++; if (rc_data[127:96] !== 32'hcbcfb0cb || rc_data[159:128] !== 32'h2b8a057b) begin errors++; $display("FAIL m256_step2_words: got %h %h expected cbcfb0cb 2b8a057b", rc_data[127:96], rc_data[159:128]); end
                    checks++; if (rc_data[511:256] !== 256'd0) begin errors++; $display("FAIL m256_upper_zero: got %h expected 0", rc_data[511:256]); end
                    checks++; if ({round_idx, aes_idx} !== 4'b0010) begin errors++; $display("FAIL m256_step2_idx: got %h expected 2", {round_idx, aes_idx}); end
                end
                s++;
            end
            if (done) dones++;
        end
        checks++; if (s !== 10 || dones !== 1) begin errors++; $display("FAIL m256_count: got steps=%0d dones=%0d expected 10 1", s, dones); end
    endtask

    task automatic test_stall;
        int s = 0, dones = 0, stalls = 0;
        bit got_done = 0, prev_valid = 0, prev_ready = 0;
        logic [511:0] prev_data = '0;
        logic [3:0]   prev_idx  = '0;
        rc_ready = 1'b0;
        kick(1'b1);
        for (int c = 0; c < 300 && !got_done; c++) begin
            @(negedge CLK);
            if (rc_valid && prev_valid && !prev_ready) begin
                stalls++;
                checks++; if (rc_data !== prev_data || {round_idx, aes_idx} !== prev_idx) begin errors++; $display("FAIL stall_stable s=%0d: got %h/%h expected %h/%h", s, {round_idx, aes_idx}, rc_data, prev_idx, prev_data); end
            end
            if (rc_valid) begin
                checks++; if (rc_data !== exp_step(1'b1, s)) begin errors++; $display("FAIL stall_data s=%0d: got %h expected %h", s, rc_data, exp_step(1'b1, s)); end
            end
            if (done) begin dones++; got_done = 1; end
            prev_valid = rc_valid; prev_data = rc_data; prev_idx = {round_idx, aes_idx};
            rc_ready = 1'($urandom % 2);
            prev_ready = rc_ready;
            if (rc_valid && rc_ready) begin
                if (s == 9) begin
                    checks++; if (rc_data[127:96] !== 32'h4ce99a54 || rc_data[511:480] !== 32'h756acc03) begin errors++; $display("FAIL stall_final_words: got %h %h expected 4ce99a54 756acc03", rc_data[127:96], rc_data[511:480]); end
                end
                s++;
            end
        end
        checks++; if (!got_done) begin errors++; $display("FAIL stall_timeout: got no done expected done within budget"); end
        checks++; if (s !== 10 || dones !== 1) begin errors++; $display("FAIL stall_count: got steps=%0d dones=%0d expected 10 1", s, dones); end
        rc_ready = 1'b1;
    endtask

    task automatic test_reset_mid;
        bit found = 0, saw_valid = 0;
        int dones = 0;
        rc_ready = 1'b1;
        kick(1'b1);
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge CLK);
            if (rc_valid && round_idx == 3'd2) found = 1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rmid_reach_round2: got not reached expected reached"); end
        #2 RESET = 1'b1;
        #1;
        checks++; if ({rc_valid, busy, done, round_idx, aes_idx} !== 7'd0 || rc_data !== 512'd0) begin errors++; $display("FAIL rmid_async_clear: got ctl=%b data=%h expected 0", {rc_valid, busy, done, round_idx, aes_idx}, rc_data); end
        @(negedge CLK);
        RESET = 1'b0;
        for (int c = 0; c < 15; c++) begin
            @(negedge CLK);
            if (done) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL rmid_no_done: got %0d expected 0", dones); end
        kick(1'b1);
        for (int c = 0; c < 5 && !saw_valid; c++) begin
            @(negedge CLK);
            if (rc_valid) saw_valid = 1;
        end
        checks++; if (!saw_valid || rc_data !== exp_step(1'b1, 0) || {round_idx, aes_idx} !== 4'd0) begin errors++; $display("FAIL rmid_restart: got valid=%b idx=%h data=%h expected rc0..3 at idx 0", saw_valid, {round_idx, aes_idx}, rc_data); end
        repeat (15) @(negedge CLK);
    endtask

    task automatic test_ignore_inputs(input bit m);
        int s = 0, dones = 0;
        rc_ready = 1'b1;
        kick(m);
        for (int c = 0; c < 25; c++) begin
            @(negedge CLK);
            if (rc_valid) begin
                checks++; if (rc_data !== exp_step(m, s)) begin errors++; $display("FAIL ignore_data m=%0d s=%0d: got %h expected %h", m, s, rc_data, exp_step(m, s)); end
                s++;
            end
            if (done) dones++;
            start   = busy || done;
            mode512 = ~mode512;
        end
        start = 1'b0;
        checks++; if (s !== 10 || dones !== 1) begin errors++; $display("FAIL ignore_count m=%0d: got steps=%0d dones=%0d expected 10 1", m, s, dones); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_idle m=%0d: got busy %b expected 0", m, busy); end
    endtask

    initial begin
        test_reset();
        test_full_512();
        test_mode256();
        test_stall();
        test_reset_mid();
        test_ignore_inputs(1'b1);
        test_ignore_inputs(1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/haraka_rc_seq.md
HARAKA_RC_SEQ -- requirements
Module: haraka_rc_seq

Interface
REQ-001 SHALL have parameter ROUNDS, default 5: Haraka rounds per permutation; ROUNDS*AES_PER_ROUND*4 SHALL NOT exceed 40.
REQ-002 SHALL have parameter AES_PER_ROUND, default 2: AES sub-rounds per Haraka round.
REQ-003 SHALL have parameter LANES, default 4: 128-bit constant lanes emitted per step.
REQ-004 SHALL have port CLK, in, 1: single clock; one clock, reset is asynchronous and active-high.
REQ-005 SHALL have port RESET, in, 1: asynchronous active-high reset.
REQ-006 SHALL have port start, in, 1: begin a constant sequence; sampled only in IDLE.
REQ-007 SHALL have port mode512, in, 1: 1 = Haraka-512 (4 lanes/step), 0 = Haraka-256 (2 lanes/step); latched at start.
REQ-008 SHALL have port rc_ready, in, 1: consumer accepts current step.
REQ-009 SHALL have port rc_valid, out, 1: rc_data holds a valid step.
REQ-010 SHALL have port rc_data, out, LANES*128: lane k at bits [128k+127:128k].
REQ-011 SHALL have port round_idx, out, clog2(ROUNDS): Haraka round of current step.
REQ-012 SHALL have port aes_idx, out, clog2(AES_PER_ROUND): AES sub-round of current step.
REQ-013 SHALL have port busy, out, 1: high in LOAD and RUN.
REQ-014 SHALL have port done, out, 1: one-cycle pulse after last step accepted.

Function
REQ-015 SHALL implement FSM IDLE -> LOAD -> RUN -> DONE -> IDLE.
REQ-016 IDLE: start=1 SHALL latch mode512, clear round/aes counters, go LOAD.
REQ-017 LOAD: SHALL register rc_data for current step, assert rc_valid next cycle, go RUN (1-cycle table latency).
REQ-018 Index for lane k SHALL be 4*AES_PER_ROUND*round + 4*aes + k in 512 mode; 2*AES_PER_ROUND*round + 2*aes + k for k<2 in 256 mode.
REQ-019 In 256 mode lanes k>=2 SHALL output zero.
REQ-020 RUN: rc_data, round_idx, aes_idx SHALL hold stable while rc_valid=1 and rc_ready=0.
REQ-021 RUN with rc_valid&rc_ready: if not last step, SHALL increment aes (wrapping to 0 and incrementing round at AES_PER_ROUND-1) and present next step the following cycle with rc_valid held high (zero-bubble).
REQ-022 Last step (round=ROUNDS-1, aes=AES_PER_ROUND-1) accepted: SHALL drop rc_valid, go DONE.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE.
REQ-024 start asserted outside IDLE SHALL be ignored; mode512 changes outside IDLE SHALL be ignored.
REQ-025 Counter arithmetic SHALL be unsigned, table index width clog2(40)=6 bits.

Reset
REQ-026 RESET=1 SHALL asynchronously force IDLE, counters 0, rc_valid=0, rc_data=0, busy=0, done=0, latched mode 0.
REQ-027 RESET mid-sequence SHALL abort with no done pulse; next start restarts from round 0.

Structure
REQ-028 The 40-entry 128-bit Haraka constant table, HARAKA_NUM_RC=40, and FSM state encoding SHALL reside in shared package haraka_pkg.
REQ-029 Table lookup SHALL be a combinational sub-module haraka_rc_rom (index in, 128-bit constant out), instantiated LANES times.
REQ-030 All outputs SHALL be registered.

Verification
REQ-031 Reset, start, mode512=1, rc_ready=1 -> first valid step lanes 0..3 = 0684704c..7b9d, 8b66b4e1..f717, 3402de2d..9114, 0ed6eae6..4f79; 10 consecutive valid cycles; done pulses once.
REQ-032 mode512=0, accept 3 steps -> step 2 (round 1, aes 0) lanes 0/1 = cbcfb0cb..7044, 7eeacdee..057b; lanes 2/3 = 0.
REQ-033 mode512=1, rc_ready toggled randomly -> data/indices stable while stalled; final step lanes = 4ce99a54..c978, ae51a51a..1235, a0c1613c..59cf, 756acc03..9da1.
REQ-034 RESET asserted at round 2 -> all outputs 0 same cycle, no done; restart yields rc[0] again.
REQ-035 start pulsed during RUN and mode512 toggled -> sequence unaffected, exactly 10 steps (512) or 10 steps with zero upper lanes (256).
